// File: rtl/wrapping_pointer_controller_if.sv
// Handshake/status bundle between producer/consumer logic and the
// wrapping pointer controller.
//   write_request / read_request : requests from producer / consumer
//   write_enable  / read_enable  : accepted strobes (combinational)
//   write_index   / read_index   : storage entries to access (registered)
//   level, full, empty           : occupancy status
//   flush                        : only with WRAPPING_POINTER_CONTROLLER_FLUSH_EN
// Modports: master = requester side, slave = controller side.
interface wrapping_pointer_controller_if #(
    parameter int unsigned Depth      = 4,
    parameter int unsigned DepthLog2  = $clog2(Depth),
    parameter int unsigned LevelWidth = $clog2(Depth + 1)
);
    logic                  write_request;
    logic                  write_enable;
    logic [DepthLog2-1:0]  write_index;
    logic                  read_request;
    logic                  read_enable;
    logic [DepthLog2-1:0]  read_index;
    logic [LevelWidth-1:0] level;
    logic                  full;
    logic                  empty;
`ifdef WRAPPING_POINTER_CONTROLLER_FLUSH_EN
    logic                  flush;
`endif

    modport master (
        output write_request,
        output read_request,
`ifdef WRAPPING_POINTER_CONTROLLER_FLUSH_EN
        output flush,
`endif
        input  write_enable,
        input  write_index,
        input  read_enable,
        input  read_index,
        input  level,
        input  full,
        input  empty
    );

    modport slave (
        input  write_request,
        input  read_request,
`ifdef WRAPPING_POINTER_CONTROLLER_FLUSH_EN
        input  flush,
`endif
        output write_enable,
        output write_index,
        output read_enable,
        output read_index,
        output level,
        output full,
        output empty
    );
endinterface

// File: rtl/wrapping_pointer_controller.sv
// Read/write pointer controller for a circular buffer of any Depth >= 2.
// Each pointer is an index plus a lap bit; full/empty come from comparing
// the pointers, level is a separately registered occupancy counter.
// Ports:
//   clk_i    : clock, all state on rising edge
//   rst_ni   : synchronous active-low reset
//   ctrl_io  : wrapping_pointer_controller_if.slave (requests in, strobes,
//              indices, level and flags out)
// Optional feature: define WRAPPING_POINTER_CONTROLLER_FLUSH_EN to add a
// flush input (in the interface) that returns all state to the reset state.
module wrapping_pointer_controller #(
    parameter int unsigned Depth      = 4,
    parameter int unsigned DepthLog2  = $clog2(Depth),
    parameter int unsigned LevelWidth = $clog2(Depth + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    wrapping_pointer_controller_if.slave  ctrl_io
);
    localparam int unsigned PtrWidth = DepthLog2 + 1;
    localparam bit IsPow2 = ((Depth & (Depth - 1)) == 0);
    localparam logic [DepthLog2-1:0] LastIdx = DepthLog2'(Depth - 1);

    // {lap, index}
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LevelWidth-1:0] level_q, level_d;
    logic                  idx_eq, full, empty, wr_en, rd_en, flush;

    // Power-of-2 depth: the index carry is the lap bit. Otherwise wrap
    // explicitly at Depth-1 so out-of-range indices never appear.
    function automatic logic [PtrWidth-1:0] advance(logic [PtrWidth-1:0] ptr);
        if (IsPow2) begin
            return ptr + PtrWidth'(1);
        end else if (ptr[DepthLog2-1:0] == LastIdx) begin
            return {~ptr[DepthLog2], {DepthLog2{1'b0}}};
        end else begin
            return ptr + PtrWidth'(1);
        end
    endfunction

`ifdef WRAPPING_POINTER_CONTROLLER_FLUSH_EN
    assign flush = ctrl_io.flush;
`else
    assign flush = 1'b0;
`endif

    assign idx_eq = (wr_ptr_q[DepthLog2-1:0] == rd_ptr_q[DepthLog2-1:0]);
    assign empty  = idx_eq & (wr_ptr_q[DepthLog2] == rd_ptr_q[DepthLog2]);
    assign full   = idx_eq & (wr_ptr_q[DepthLog2] != rd_ptr_q[DepthLog2]);
    // full and empty are exclusive, so the "full + both" and "empty + both"
    // tie-breaks fall straight out of these two gates.
    assign wr_en  = ctrl_io.write_request & ~full & ~flush;
    assign rd_en  = ctrl_io.read_request & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = advance(wr_ptr_q);
            if (rd_en) rd_ptr_d = advance(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LevelWidth'(1);
                2'b01:   level_d = level_q - LevelWidth'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign ctrl_io.write_enable = wr_en;
    assign ctrl_io.read_enable  = rd_en;
    assign ctrl_io.write_index  = wr_ptr_q[DepthLog2-1:0];
    assign ctrl_io.read_index   = rd_ptr_q[DepthLog2-1:0];
    assign ctrl_io.level        = level_q;
    assign ctrl_io.full         = full;
    assign ctrl_io.empty        = empty;

    // The level counter and the pointer-derived flags must tell the same story.
    level_flags_agree: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (empty == (level_q == '0)) && (full == (level_q == LevelWidth'(Depth))));

    indices_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wr_ptr_q[DepthLog2-1:0] <= LastIdx) && (rd_ptr_q[DepthLog2-1:0] <= LastIdx));
endmodule

// File: tb/tb_wrapping_pointer_controller.sv
// Directed bench: Depth=5 instance for the main scenarios, Depth=4 instance
// for the power-of-2 interleaved run against a small occupancy model.
module tb_wrapping_pointer_controller;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_failed;

    wrapping_pointer_controller_if #(.Depth(5)) ctrl5 ();
    wrapping_pointer_controller_if #(.Depth(4)) ctrl4 ();

    wrapping_pointer_controller #(.Depth(5)) dut5 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ctrl_io (ctrl5)
    );

    wrapping_pointer_controller #(.Depth(4)) dut4 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ctrl_io (ctrl4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs != exp) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state5(input string tag, input int unsigned wi, input int unsigned ri,
                                input int unsigned lvl);
        check_eq({tag, ".wi"},    32'(ctrl5.write_index), wi);
        check_eq({tag, ".ri"},    32'(ctrl5.read_index), ri);
        check_eq({tag, ".level"}, 32'(ctrl5.level), lvl);
        check_eq({tag, ".full"},  32'(ctrl5.full), (lvl == 5) ? 1 : 0);
        check_eq({tag, ".empty"}, 32'(ctrl5.empty), (lvl == 0) ? 1 : 0);
    endtask

    // Depth=4 stimulus, {write_request, read_request} per cycle.
    logic [1:0] vec4 [16] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01};

    initial begin
        int mlvl;
        int mw;
        int mr;
        int exp_we;
        int exp_re;
        logic [1:0] v;

        n_tests  = 0;
        n_failed = 0;
        rst_n = 1'b0;
        ctrl5.write_request = 1'b0;
        ctrl5.read_request  = 1'b0;
        ctrl4.write_request = 1'b0;
        ctrl4.read_request  = 1'b0;
`ifdef WRAPPING_POINTER_CONTROLLER_FLUSH_EN
        ctrl5.flush = 1'b0;
        ctrl4.flush = 1'b0;
`endif
        repeat (2) cycle();
        rst_n = 1'b1;
        #1;
        check_state5("reset", 0, 0, 0);
        check_eq("reset.we", 32'(ctrl5.write_enable), 0);
        check_eq("reset.re", 32'(ctrl5.read_enable), 0);

        // Fill all five entries.
        ctrl5.write_request = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check_eq($sformatf("fill%0d.we", i), 32'(ctrl5.write_enable), 1);
            cycle();
            check_state5($sformatf("fill%0d", i), i % 5, 0, i);
        end

        // Sixth write is rejected and changes nothing.
        #1;
        check_eq("over.we", 32'(ctrl5.write_enable), 0);
        check_eq("over.re", 32'(ctrl5.read_enable), 0);
        cycle();
        check_state5("over", 0, 0, 5);

        // Full with both requests: read wins.
        ctrl5.read_request = 1'b1;
        #1;
        check_eq("fullboth.re", 32'(ctrl5.read_enable), 1);
        check_eq("fullboth.we", 32'(ctrl5.write_enable), 0);
        cycle();
        check_state5("fullboth", 0, 1, 4);

        // Drain down to one held entry.
        ctrl5.write_request = 1'b0;
        repeat (3) cycle();
        ctrl5.read_request = 1'b0;
        check_state5("drain", 0, 4, 1);

        // 13 write/read pairs with one entry held; both pointers wrap.
        ctrl5.write_request = 1'b1;
        ctrl5.read_request  = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            #1;
            check_eq($sformatf("wrap%0d.we", k), 32'(ctrl5.write_enable), 1);
            check_eq($sformatf("wrap%0d.re", k), 32'(ctrl5.read_enable), 1);
            cycle();
            check_state5($sformatf("wrap%0d", k), k % 5, (4 + k) % 5, 1);
        end
        ctrl5.read_request = 1'b0;

        // Two more writes -> level 3, then a one-cycle reset.
        repeat (2) cycle();
        check_state5("lvl3", 0, 2, 3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        ctrl5.write_request = 1'b0;
        check_state5("midreset", 0, 0, 0);

        // Empty with both requests: write wins.
        ctrl5.write_request = 1'b1;
        ctrl5.read_request  = 1'b1;
        #1;
        check_eq("emptyboth.we", 32'(ctrl5.write_enable), 1);
        check_eq("emptyboth.re", 32'(ctrl5.read_enable), 0);
        cycle();
        ctrl5.read_request = 1'b0;
        check_state5("emptyboth", 1, 0, 1);

`ifdef WRAPPING_POINTER_CONTROLLER_FLUSH_EN
        repeat (2) cycle();
        check_state5("preflush", 3, 0, 3);
        ctrl5.flush = 1'b1;
        #1;
        check_eq("flush.we", 32'(ctrl5.write_enable), 0);
        cycle();
        ctrl5.flush = 1'b0;
        check_state5("flush", 0, 0, 0);
`endif
        ctrl5.write_request = 1'b0;
        ctrl5.read_request  = 1'b0;

        // Depth=4 interleaved run against an occupancy model.
        mlvl = 0;
        mw   = 0;
        mr   = 0;
        for (int c = 0; c < 16; c++) begin
            v = vec4[c];
            ctrl4.write_request = v[1];
            ctrl4.read_request  = v[0];
            #1;
            exp_we = (v[1] && mlvl != 4) ? 1 : 0;
            exp_re = (v[0] && mlvl != 0) ? 1 : 0;
            check_eq($sformatf("d4c%0d.we", c), 32'(ctrl4.write_enable), exp_we);
            check_eq($sformatf("d4c%0d.re", c), 32'(ctrl4.read_enable), exp_re);
            if (exp_we != 0) mw = (mw + 1) % 4;
            if (exp_re != 0) mr = (mr + 1) % 4;
            mlvl = mlvl + exp_we - exp_re;
            cycle();
            check_eq($sformatf("d4c%0d.wi", c),    32'(ctrl4.write_index), mw);
            check_eq($sformatf("d4c%0d.ri", c),    32'(ctrl4.read_index), mr);
            check_eq($sformatf("d4c%0d.level", c), 32'(ctrl4.level), mlvl);
            check_eq($sformatf("d4c%0d.full", c),  32'(ctrl4.full), (mlvl == 4) ? 1 : 0);
            check_eq($sformatf("d4c%0d.empty", c), 32'(ctrl4.empty), (mlvl == 0) ? 1 : 0);
        end
        ctrl4.write_request = 1'b0;
        ctrl4.read_request  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
